// File: rtl/apb_modport.sv
// APB master with two zero-wait 256x8 memory slaves behind it.
// Only the transfer request, addresses and data are exposed.
module apb_modport_slave #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          i_psel,
    input  logic          i_penable,
    input  logic          i_pwrite,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_prdata,
    output logic          o_pready
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge pclk) begin
        if (presetn) begin
            for (int i = 0; i < 2**AW; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_psel && i_penable && i_pwrite) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_pready = i_psel & i_penable;
    assign o_prdata = r_mem[i_addr];
endmodule

module apb_modport #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              transfer,
    input  logic              READ_WRITE,
    input  logic [ADDR_W-1:0] apb_write_paddr,
    input  logic [ADDR_W-1:0] apb_read_paddr,
    input  logic [DATA_W-1:0] apb_write_data,
    output logic [DATA_W-1:0] apb_read_data_out
);
    localparam int OW = ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            r_state;
    logic              r_psel1;
    logic              r_psel2;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rdata;

    logic [ADDR_W-1:0] w_paddr_in;
    logic [DATA_W-1:0] w_prdata1;
    logic [DATA_W-1:0] w_prdata2;
    logic [DATA_W-1:0] w_prdata;
    logic              w_pready1;
    logic              w_pready2;
    logic              w_pready;

    assign w_paddr_in = READ_WRITE ? apb_read_paddr : apb_write_paddr;
    assign w_pready = (r_psel1 & w_pready1) | (r_psel2 & w_pready2);
    assign w_prdata = r_psel2 ? w_prdata2 : w_prdata1;
    assign apb_read_data_out = r_rdata;

    // Reset wins over completion, so an interrupted transfer leaves no trace.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            r_state   <= IDLE;
            r_psel1   <= 1'b0;
            r_psel2   <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_rdata   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (transfer) begin
                        r_state  <= SETUP;
                        r_pwrite <= ~READ_WRITE;
                        r_paddr  <= w_paddr_in;
                        r_pwdata <= apb_write_data;
                        r_psel1  <= ~w_paddr_in[OW];
                        r_psel2  <= w_paddr_in[OW];
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_pready) begin
                        if (!r_pwrite) begin
                            r_rdata <= w_prdata;
                        end
                        r_penable <= 1'b0;
                        if (transfer) begin
                            r_state  <= SETUP;
                            r_pwrite <= ~READ_WRITE;
                            r_paddr  <= w_paddr_in;
                            r_pwdata <= apb_write_data;
                            r_psel1  <= ~w_paddr_in[OW];
                            r_psel2  <= w_paddr_in[OW];
                        end else begin
                            r_state <= IDLE;
                            r_psel1 <= 1'b0;
                            r_psel2 <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    apb_modport_slave #(.AW(OW), .DW(DATA_W)) u_slave1 (
        .pclk      (pclk),
        .presetn   (presetn),
        .i_psel    (r_psel1),
        .i_penable (r_penable),
        .i_pwrite  (r_pwrite),
        .i_addr    (r_paddr[OW-1:0]),
        .i_wdata   (r_pwdata),
        .o_prdata  (w_prdata1),
        .o_pready  (w_pready1)
    );

    apb_modport_slave #(.AW(OW), .DW(DATA_W)) u_slave2 (
        .pclk      (pclk),
        .presetn   (presetn),
        .i_psel    (r_psel2),
        .i_penable (r_penable),
        .i_pwrite  (r_pwrite),
        .i_addr    (r_paddr[OW-1:0]),
        .i_wdata   (r_pwdata),
        .o_prdata  (w_prdata2),
        .o_pready  (w_pready2)
    );
endmodule

// File: tb/tb_apb_modport.sv
// Bench for apb_modport: directed scenarios plus random op bursts,
// checked against a flat 512-byte memory model of both slaves.
module tb_apb_modport;
    logic       pclk;
    logic       presetn;
    logic       transfer;
    logic       READ_WRITE;
    logic [8:0] apb_write_paddr;
    logic [8:0] apb_read_paddr;
    logic [7:0] apb_write_data;
    logic [7:0] apb_read_data_out;

    typedef struct {
        bit         rd;
        logic [8:0] a;
        logic [7:0] d;
    } op_t;

    int        n_chk;
    int        n_fail;
    logic [7:0] mdl_mem [512];
    logic [7:0] exp_rd;
    op_t       q[$];

    apb_modport dut (
        .pclk              (pclk),
        .presetn           (presetn),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_read_paddr    (apb_read_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_data_out (apb_read_data_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bus phase as seen on the APB: 0 idle, 1 setup, 2 access
    function automatic logic [1:0] phase();
        if (!dut.r_psel1 && !dut.r_psel2) return 2'd0;
        return dut.r_penable ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [1:0] sel_of(input logic [8:0] a);
        return a[8] ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input op_t o);
        READ_WRITE      = o.rd;
        apb_read_paddr  = o.rd ? o.a : 9'($urandom);
        apb_write_paddr = o.rd ? 9'($urandom) : o.a;
        apb_write_data  = o.d;
    endtask

    task automatic scramble();
        READ_WRITE      = 1'($urandom);
        apb_read_paddr  = 9'($urandom);
        apb_write_paddr = 9'($urandom);
        apb_write_data  = 8'($urandom);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) mdl_mem[i] = 8'h00;
        exp_rd = 8'h00;
    endtask

    task automatic do_reset();
        presetn  = 1'b1;
        transfer = 1'b0;
        tick();
        presetn = 1'b0;
        model_reset();
        chk("rst_phase", 16'(phase()), 16'd0);
        chk("rst_rdata", 16'(apb_read_data_out), 16'(exp_rd));
        chk("rst_pwrite", 16'(dut.r_pwrite), 16'd0);
        chk("rst_paddr", 16'(dut.r_paddr), 16'd0);
    endtask

    // Runs q back to back with transfer held, starting from IDLE.
    task automatic run_q();
        op_t o;
        chk("pre_idle", 16'(phase()), 16'd0);
        drive(q[0]);
        transfer = 1'b1;
        tick();
        for (int i = 0; i < q.size(); i++) begin
            o = q[i];
            chk("setup_phase", 16'(phase()), 16'd1);
            chk("setup_sel", 16'({dut.r_psel2, dut.r_psel1}),
                16'(sel_of(o.a)));
            scramble();
            transfer = 1'($urandom);
            tick();
            chk("access_phase", 16'(phase()), 16'd2);
            chk("access_rdata", 16'(apb_read_data_out), 16'(exp_rd));
            if (i + 1 < q.size()) begin
                drive(q[i+1]);
                transfer = 1'b1;
            end else begin
                scramble();
                transfer = 1'b0;
            end
            tick();
            if (o.rd) exp_rd = mdl_mem[o.a];
            else mdl_mem[o.a] = o.d;
            chk("done_rdata", 16'(apb_read_data_out), 16'(exp_rd));
        end
        chk("end_idle", 16'(phase()), 16'd0);
        q.delete();
    endtask

    task automatic push(input bit rd, input logic [8:0] a,
                        input logic [7:0] d);
        op_t o;
        o.rd = rd;
        o.a  = a;
        o.d  = d;
        q.push_back(o);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        presetn = 1'b0;
        transfer = 1'b0;
        scramble();
        model_reset();
        tick();
        do_reset();

        push(1, 9'h0FF, 8'h00); run_q();
        chk("uninit_rd", 16'(apb_read_data_out), 16'h00);
        push(0, 9'h0FF, 8'h77); run_q();
        chk("wr_keeps_rd", 16'(apb_read_data_out), 16'h00);

        push(0, 9'h012, 8'hA5); run_q();
        push(1, 9'h012, 8'h00); run_q();
        chk("wr_rd_s1", 16'(apb_read_data_out), 16'hA5);

        push(0, 9'h105, 8'h3C); run_q();
        push(0, 9'h005, 8'hC3); run_q();
        push(1, 9'h105, 8'h00); run_q();
        chk("iso_s2", 16'(apb_read_data_out), 16'h3C);
        push(1, 9'h005, 8'h00); run_q();
        chk("iso_s1", 16'(apb_read_data_out), 16'hC3);

        push(0, 9'h000, 8'h11);
        push(0, 9'h001, 8'h22);
        push(0, 9'h1FF, 8'hFF);
        run_q();
        push(1, 9'h000, 8'h00); run_q();
        chk("b2b_0", 16'(apb_read_data_out), 16'h11);
        push(1, 9'h001, 8'h00); run_q();
        chk("b2b_1", 16'(apb_read_data_out), 16'h22);
        push(1, 9'h1FF, 8'h00); run_q();
        chk("b2b_2", 16'(apb_read_data_out), 16'hFF);

        // Reset lands on the edge that would complete the write
        apb_write_paddr = 9'h020;
        apb_write_data  = 8'h99;
        READ_WRITE      = 1'b0;
        transfer        = 1'b1;
        tick();
        chk("mid_setup", 16'(phase()), 16'd1);
        tick();
        chk("mid_access", 16'(phase()), 16'd2);
        do_reset();
        push(1, 9'h020, 8'h00); run_q();
        chk("mid_rst_rd", 16'(apb_read_data_out), 16'h00);
        push(1, 9'h005, 8'h00); run_q();
        chk("rst_clr_mem", 16'(apb_read_data_out), 16'h00);

        push(0, 9'h012, 8'hA5); run_q();
        push(1, 9'h012, 8'h00); run_q();
        chk("latency_rd", 16'(apb_read_data_out), 16'hA5);
        tick();
        chk("stay_idle", 16'(phase()), 16'd0);

        for (int k = 0; k < 60; k++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                push(1'($urandom), {1'($urandom), 5'd0, 3'($urandom)},
                     8'($urandom));
            end
            run_q();
            if ($urandom_range(0, 3) == 0) begin
                transfer = 1'b0;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
